// File: rtl/branch_target_predictor_if.sv
// Purpose:
//   Bundles the fetch-side lookup, ID-side training and statistics signals
//   of the branch target predictor into one interface.
// Ports / signals:
//   if_valid, if_pc               fetch lookup request (master -> slave)
//   pred_taken, pred_target       zero-latency prediction (slave -> master)
//   upd_*                         ID-stage resolution update (master -> slave)
//   inv_all                       invalidate all entries (master -> slave)
//   stat_updates, stat_mispredicts  statistics counters (slave -> master)
// Modports: master = core side, slave = predictor side.
interface branch_target_predictor_if #(
    parameter int XLEN   = 32,
    parameter int STAT_W = 32
);
    logic              if_valid;
    logic [XLEN-1:0]   if_pc;
    logic              pred_taken;
    logic [XLEN-1:0]   pred_target;
    logic              upd_valid;
    logic [XLEN-1:0]   upd_pc;
    logic              upd_is_branch;
    logic              upd_is_jump;
    logic              upd_taken;
    logic [XLEN-1:0]   upd_target;
    logic              upd_mispredict;
    logic              inv_all;
    logic [STAT_W-1:0] stat_updates;
    logic [STAT_W-1:0] stat_mispredicts;

    modport master (
        output if_valid, if_pc,
        output upd_valid, upd_pc, upd_is_branch, upd_is_jump,
        output upd_taken, upd_target, upd_mispredict, inv_all,
        input  pred_taken, pred_target, stat_updates, stat_mispredicts
    );

    modport slave (
        input  if_valid, if_pc,
        input  upd_valid, upd_pc, upd_is_branch, upd_is_jump,
        input  upd_taken, upd_target, upd_mispredict, inv_all,
        output pred_taken, pred_target, stat_updates, stat_mispredicts
    );
endinterface

// File: rtl/branch_target_predictor.sv
// Purpose:
//   Direct-mapped branch target buffer with 2-bit saturating direction
//   counters. Predicts the next PC combinationally in IF and is trained
//   by branch/jump resolutions from ID. Also counts accepted updates and
//   mispredicts for performance analysis.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    branch_target_predictor_if.slave (lookup, update, stats)
module branch_target_predictor #(
    parameter int         XLEN     = 32,
    parameter int         ENTRIES  = 64,
    parameter int         TAG_W    = 10,
    parameter logic [1:0] CNT_INIT = 2'd1,
    parameter int         STAT_W   = 32
) (
    input  logic clk,
    input  logic reset,
    branch_target_predictor_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] validQ;
    logic [ENTRIES-1:0] isJumpQ;
    logic [TAG_W-1:0]   tagQ    [ENTRIES];
    logic [XLEN-1:0]    targetQ [ENTRIES];
    logic [1:0]         cntQ    [ENTRIES];
    logic [STAT_W-1:0]  statUpdatesQ;
    logic [STAT_W-1:0]  statUpdatesD;
    logic [STAT_W-1:0]  statMispredictsQ;
    logic [STAT_W-1:0]  statMispredictsD;

    logic [IDX_W-1:0] lkIdx;
    logic [TAG_W-1:0] lkTag;
    logic             lkHit;
    logic             lkTaken;

    logic [IDX_W-1:0] updIdx;
    logic [TAG_W-1:0] updTag;
    logic             updAccept;
    logic             updHit;
    logic             entWe;
    logic [1:0]       entCntD;
    logic [XLEN-1:0]  entTargetD;

    // Only the index and tag slices of each PC are used; the remaining
    // bits are folded into a sink to document that this is intentional.
    logic unusedPcBits;
    assign unusedPcBits = ^{bus.if_pc, bus.upd_pc};

    // Zero-latency lookup: a jump entry always redirects, a branch entry
    // redirects when its counter is in one of the two taken states.
    assign lkIdx   = bus.if_pc[IDX_W+1:2];
    assign lkTag   = bus.if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign lkHit   = bus.if_valid & validQ[lkIdx] & (tagQ[lkIdx] == lkTag);
    assign lkTaken = lkHit & (isJumpQ[lkIdx] | cntQ[lkIdx][1]);

    assign bus.pred_taken  = lkTaken;
    assign bus.pred_target = lkTaken ? targetQ[lkIdx] : bus.if_pc + XLEN'(4);

    assign updIdx    = bus.upd_pc[IDX_W+1:2];
    assign updTag    = bus.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign updAccept = bus.upd_valid & (bus.upd_is_branch | bus.upd_is_jump);
    assign updHit    = validQ[updIdx] & (tagQ[updIdx] == updTag);

    // Next state of the single entry touched by an update. inv_all has
    // priority and drops the table write; a not-taken miss allocates nothing.
    // The is_jump flag alone decides jump handling, so branch+jump acts as jump.
    always_comb begin
        entWe      = 1'b0;
        entCntD    = cntQ[updIdx];
        entTargetD = targetQ[updIdx];
        if (updAccept && !bus.inv_all && reset) begin
            if (updHit) begin
                entWe = 1'b1;
                if (bus.upd_is_jump) begin
                    entCntD = 2'd3;
                end else if (bus.upd_taken) begin
                    entCntD = (cntQ[updIdx] == 2'd3) ? 2'd3 : cntQ[updIdx] + 2'd1;
                end else begin
                    entCntD = (cntQ[updIdx] == 2'd0) ? 2'd0 : cntQ[updIdx] - 2'd1;
                end
                if (bus.upd_taken) begin
                    entTargetD = bus.upd_target;
                end
            end else if (bus.upd_taken) begin
                entWe      = 1'b1;
                entCntD    = bus.upd_is_jump ? 2'd3 : 2'd2;
                entTargetD = bus.upd_target;
            end
        end
    end

    // Statistics keep counting even when inv_all drops the table write.
    always_comb begin
        statUpdatesD     = statUpdatesQ + STAT_W'(updAccept);
        statMispredictsD = statMispredictsQ + STAT_W'(bus.upd_valid & bus.upd_mispredict);
    end

    // Control state: valid bits, direction counters and statistics are the
    // only state that reset has to bring to a known value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            validQ <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                cntQ[i] <= CNT_INIT;
            end
            statUpdatesQ     <= '0;
            statMispredictsQ <= '0;
        end else begin
            if (bus.inv_all) begin
                validQ <= '0;
            end else if (entWe) begin
                validQ[updIdx] <= 1'b1;
            end
            if (entWe) begin
                cntQ[updIdx] <= entCntD;
            end
            statUpdatesQ     <= statUpdatesD;
            statMispredictsQ <= statMispredictsD;
        end
    end

    // Payload is only meaningful behind a set valid bit, so it needs no reset.
    always_ff @(posedge clk) begin
        if (entWe) begin
            tagQ[updIdx]    <= updTag;
            targetQ[updIdx] <= entTargetD;
            isJumpQ[updIdx] <= bus.upd_is_jump;
        end
    end

    assign bus.stat_updates     = statUpdatesQ;
    assign bus.stat_mispredicts = statMispredictsQ;
endmodule

// File: tb/tb_branch_target_predictor.sv
// Purpose:
//   Self-checking bench for branch_target_predictor (ENTRIES=64): a table of
//   directed vectors, a hand-written async reset sequence and a randomized
//   phase checked against a behavioural table model.
module tb_branch_target_predictor;
    typedef struct {
        logic        ifValid;
        logic [31:0] ifPc;
        logic        updValid;
        logic        isBr;
        logic        isJmp;
        logic        taken;
        logic        mis;
        logic        inv;
        logic [31:0] updPc;
        logic [31:0] updTgt;
        logic        expTaken;
        logic [31:0] expTarget;
        logic [31:0] expUpd;
        logic [31:0] expMis;
    } vec_t;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    branch_target_predictor_if #(.XLEN(32), .STAT_W(32)) bus ();

    branch_target_predictor #(
        .XLEN(32), .ENTRIES(64), .TAG_W(10), .CNT_INIT(2'd1), .STAT_W(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: one record per table slot plus two statistics.
    bit          mValid  [64];
    int unsigned mTag    [64];
    logic [31:0] mTarget [64];
    bit          mJump   [64];
    int          mCnt    [64];
    logic [31:0] mUpd;
    logic [31:0] mMis;

    function automatic vec_t mk(input logic iv, input logic [31:0] ipc,
                                input logic uv, input logic br, input logic jm,
                                input logic tk, input logic ms, input logic iinv,
                                input logic [31:0] upc, input logic [31:0] utg,
                                input logic et, input logic [31:0] etg,
                                input logic [31:0] eu, input logic [31:0] em);
        vec_t v;
        v.ifValid = iv;  v.ifPc = ipc;  v.updValid = uv; v.isBr = br;
        v.isJmp = jm;    v.taken = tk;  v.mis = ms;      v.inv = iinv;
        v.updPc = upc;   v.updTgt = utg;
        v.expTaken = et; v.expTarget = etg; v.expUpd = eu; v.expMis = em;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        bus.if_valid       = v.ifValid;
        bus.if_pc          = v.ifPc;
        bus.upd_valid      = v.updValid;
        bus.upd_is_branch  = v.isBr;
        bus.upd_is_jump    = v.isJmp;
        bus.upd_taken      = v.taken;
        bus.upd_mispredict = v.mis;
        bus.inv_all        = v.inv;
        bus.upd_pc         = v.updPc;
        bus.upd_target     = v.updTgt;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 64; i++) begin
            mValid[i] = 0;
            mCnt[i]   = 1;
        end
        mUpd = 0;
        mMis = 0;
    endtask

    task automatic modelPredict(input logic iv, input logic [31:0] pc,
                                output logic t, output logic [31:0] tgt);
        int unsigned i;
        int unsigned tg;
        i   = (pc / 4) % 64;
        tg  = (pc / 256) % 1024;
        t   = iv && mValid[i] && (mTag[i] == tg) && (mJump[i] || mCnt[i] >= 2);
        tgt = t ? mTarget[i] : pc + 32'd4;
    endtask

    // Applies the rules for one clock edge using the inputs currently driven.
    task automatic modelUpdate();
        int unsigned i;
        int unsigned tg;
        bit          accepted;
        i        = (bus.upd_pc / 4) % 64;
        tg       = (bus.upd_pc / 256) % 1024;
        accepted = bus.upd_valid && (bus.upd_is_branch || bus.upd_is_jump);
        if (accepted) mUpd = mUpd + 1;
        if (bus.upd_valid && bus.upd_mispredict) mMis = mMis + 1;
        if (bus.inv_all) begin
            for (int k = 0; k < 64; k++) mValid[k] = 0;
        end else if (accepted) begin
            if (mValid[i] && mTag[i] == tg) begin
                if (bus.upd_is_jump) mCnt[i] = 3;
                else if (bus.upd_taken) mCnt[i] = (mCnt[i] + 1 > 3) ? 3 : mCnt[i] + 1;
                else mCnt[i] = (mCnt[i] - 1 < 0) ? 0 : mCnt[i] - 1;
                if (bus.upd_taken) mTarget[i] = bus.upd_target;
                mJump[i] = bus.upd_is_jump;
            end else if (bus.upd_taken) begin
                mValid[i]  = 1;
                mTag[i]    = tg;
                mTarget[i] = bus.upd_target;
                mJump[i]   = bus.upd_is_jump;
                mCnt[i]    = bus.upd_is_jump ? 3 : 2;
            end
        end
    endtask

    function automatic logic [31:0] randPc();
        logic [31:0] hi;
        hi = $urandom & 32'hFFFC_0000;
        return hi | (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
    endfunction

    vec_t vecs[$];
    logic        expT;
    logic [31:0] expTg;
    int          kind;

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #12 reset = 1'b1;
        @(posedge clk);
        #1;

        //           iv pc            uv br jm tk ms inv upc           utgt          et  etgt          upd mis
        vecs.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 0,            0,            0, 32'h104, 0,  0));
        vecs.push_back(mk(1, 32'h100, 1, 1, 0, 1, 0, 0, 32'h100,      32'h80,       0, 32'h104, 0,  0));
        vecs.push_back(mk(1, 32'h100, 1, 1, 0, 0, 0, 0, 32'h100,      0,            1, 32'h80,  1,  0));
        vecs.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 0,            0,            0, 32'h104, 2,  0));
        vecs.push_back(mk(1, 32'h100, 1, 1, 0, 1, 0, 0, 32'h100,      32'h80,       0, 32'h104, 2,  0));
        vecs.push_back(mk(1, 32'h100, 1, 1, 0, 1, 0, 0, 32'h100,      32'h80,       1, 32'h80,  3,  0));
        vecs.push_back(mk(1, 32'h100, 1, 1, 0, 1, 0, 0, 32'h100,      32'h80,       1, 32'h80,  4,  0));
        vecs.push_back(mk(1, 32'h100, 1, 1, 0, 1, 0, 0, 32'h100,      32'h80,       1, 32'h80,  5,  0));
        vecs.push_back(mk(1, 32'h100, 1, 1, 0, 0, 0, 0, 32'h100,      0,            1, 32'h80,  6,  0));
        vecs.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 0,            0,            1, 32'h80,  7,  0));
        vecs.push_back(mk(1, 32'h200, 0, 0, 0, 0, 0, 0, 0,            0,            0, 32'h204, 7,  0));
        vecs.push_back(mk(1, 32'h200, 1, 1, 0, 1, 0, 0, 32'h200,      32'h300,      0, 32'h204, 7,  0));
        vecs.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 0,            0,            0, 32'h104, 8,  0));
        vecs.push_back(mk(1, 32'h200, 0, 0, 0, 0, 0, 0, 0,            0,            1, 32'h300, 8,  0));
        vecs.push_back(mk(1, 32'h100, 1, 1, 0, 1, 0, 0, 32'h100,      32'h500,      0, 32'h104, 8,  0));
        vecs.push_back(mk(1, 32'h100, 1, 1, 0, 0, 0, 0, 32'h100,      0,            1, 32'h500, 9,  0));
        vecs.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 0,            0,            0, 32'h104, 10, 0));
        vecs.push_back(mk(1, 32'h40,  1, 0, 1, 1, 0, 0, 32'h40,       32'h400,      0, 32'h44,  10, 0));
        vecs.push_back(mk(1, 32'h40,  1, 1, 0, 0, 0, 0, 32'h40,       0,            1, 32'h400, 11, 0));
        vecs.push_back(mk(1, 32'h40,  1, 1, 0, 0, 0, 0, 32'h40,       0,            1, 32'h400, 12, 0));
        vecs.push_back(mk(1, 32'h40,  0, 0, 0, 0, 0, 0, 0,            0,            0, 32'h44,  13, 0));
        vecs.push_back(mk(1, 32'h100, 1, 1, 1, 1, 0, 0, 32'h100,      32'h600,      0, 32'h104, 13, 0));
        vecs.push_back(mk(0, 32'h100, 0, 0, 0, 0, 0, 0, 0,            0,            0, 32'h104, 14, 0));
        vecs.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 0,            0,            1, 32'h600, 14, 0));
        vecs.push_back(mk(1, 32'h300, 1, 0, 0, 1, 1, 0, 32'h300,      32'h700,      0, 32'h304, 14, 0));
        vecs.push_back(mk(1, 32'h300, 0, 0, 0, 0, 0, 0, 0,            0,            0, 32'h304, 14, 1));
        vecs.push_back(mk(1, 32'h100, 1, 1, 0, 1, 1, 1, 32'h40,       32'h900,      1, 32'h600, 14, 1));
        vecs.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 0,            0,            0, 32'h104, 15, 2));
        vecs.push_back(mk(1, 32'h40,  0, 0, 0, 0, 0, 0, 0,            0,            0, 32'h44,  15, 2));
        vecs.push_back(mk(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0,      0,            0, 32'h0,   15, 2));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d.taken", i), 32'(bus.pred_taken), 32'(vecs[i].expTaken));
            checkOutput($sformatf("vec%0d.target", i), bus.pred_target, vecs[i].expTarget);
            checkOutput($sformatf("vec%0d.statUpd", i), bus.stat_updates, vecs[i].expUpd);
            checkOutput($sformatf("vec%0d.statMis", i), bus.stat_mispredicts, vecs[i].expMis);
            @(posedge clk);
            #1;
        end

        // Retrain one entry, then assert reset mid-cycle and check that state
        // clears without any clock edge.
        applyStimulus(mk(1, 32'h100, 1, 1, 0, 1, 1, 0, 32'h100, 32'h80, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        applyStimulus(mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        checkOutput("retrain.taken", 32'(bus.pred_taken), 32'd1);
        checkOutput("retrain.target", bus.pred_target, 32'h80);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("asyncReset.statUpd", bus.stat_updates, 32'd0);
        checkOutput("asyncReset.statMis", bus.stat_mispredicts, 32'd0);
        checkOutput("asyncReset.taken", 32'(bus.pred_taken), 32'd0);
        checkOutput("asyncReset.target", bus.pred_target, 32'h104);

        // An update presented across an edge while reset is held is discarded.
        applyStimulus(mk(1, 32'h40, 1, 0, 1, 1, 1, 0, 32'h40, 32'h400, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(mk(1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        checkOutput("resetDrop.taken", 32'(bus.pred_taken), 32'd0);
        checkOutput("resetDrop.target", bus.pred_target, 32'h44);
        checkOutput("resetDrop.statUpd", bus.stat_updates, 32'd0);
        checkOutput("resetDrop.statMis", bus.stat_mispredicts, 32'd0);
        @(posedge clk);
        #1;

        // Randomized phase; DUT state now equals a freshly reset table.
        modelReset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            kind = int'($urandom_range(0, 3));
            bus.if_valid       = ($urandom_range(0, 7) != 0);
            bus.if_pc          = randPc();
            bus.upd_valid      = ($urandom_range(0, 3) != 0);
            bus.upd_is_branch  = kind[0];
            bus.upd_is_jump    = kind[1];
            bus.upd_taken      = kind[1] ? 1'b1 : 1'($urandom_range(0, 1));
            bus.upd_mispredict = ($urandom_range(0, 3) == 0);
            bus.inv_all        = ($urandom_range(0, 31) == 0);
            bus.upd_pc         = randPc();
            bus.upd_target     = $urandom & 32'hFFFF_FFFE;
            @(negedge clk);
            modelPredict(bus.if_valid, bus.if_pc, expT, expTg);
            checkOutput($sformatf("rand%0d.taken", cyc), 32'(bus.pred_taken), 32'(expT));
            checkOutput($sformatf("rand%0d.target", cyc), bus.pred_target, expTg);
            checkOutput($sformatf("rand%0d.statUpd", cyc), bus.stat_updates, mUpd);
            checkOutput($sformatf("rand%0d.statMis", cyc), bus.stat_mispredicts, mMis);
            @(posedge clk);
            modelUpdate();
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
